// File: rtl/multi_dataflow_cfg_master.sv
// multi_dataflow_cfg_master: periph-bus initiator that acquires the HWPE, writes the job registers, triggers and waits for end-of-job.
// Optional macro CFG_MASTER_TIMEOUT_EN bounds the end-of-job wait to TIMEOUT_CYCLES and flags error_o on expiry.
//
//   state      | meaning
//   S_IDLE     | waiting for start_i; shadow writable
//   S_ACQ_REQ  | read of ACQUIRE presented, waiting for grant
//   S_ACQ_RSP  | waiting for ACQUIRE response (bit 31 = refused)
//   S_BACKOFF  | refused; down-count RETRY_CYCLES before retrying
//   S_WR_REQ   | write of shadow[idx] presented, waiting for grant
//   S_WR_RSP   | waiting for write response
//   S_TRIG_REQ | write of 0 to TRIGGER presented, waiting for grant
//   S_TRIG_RSP | waiting for trigger write response
//   S_WAIT_EVT | job running; waiting for evt_i
module multi_dataflow_cfg_master #(
    parameter int unsigned N_REGS         = 26,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned ID_WIDTH       = 10,
    parameter int unsigned PERIPH_ID      = 0,
    parameter int unsigned RETRY_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned IDX_W         = $clog2(N_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_we_i,
    input  logic [IDX_W-1:0]    cfg_idx_i,
    input  logic [31:0]         cfg_data_i,
    input  logic                start_i,
    input  logic                evt_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [7:0]          job_id_o,
    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic [31:0]         periph_r_data_i,
    input  logic                periph_r_valid_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i
);

    localparam int unsigned     RETRY_W  = $clog2(RETRY_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [31:0]     ADDR_TRIGGER = BASE_ADDR;
    localparam logic [31:0]     ADDR_ACQUIRE = BASE_ADDR + 32'h4;

    typedef enum logic [3:0] {
        S_IDLE, S_ACQ_REQ, S_ACQ_RSP, S_BACKOFF, S_WR_REQ,
        S_WR_RSP, S_TRIG_REQ, S_TRIG_RSP, S_WAIT_EVT
    } state_t;

    state_t             state_q;
    logic [31:0]        shadow_q [N_REGS];
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [RETRY_W-1:0] retry_q;
    logic               req_q;
    logic               wen_q;
    logic [31:0]        add_q;
    logic [31:0]        data_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [7:0]         job_id_q;
    logic               id_bad;
    logic               unused_rdata;

`ifdef CFG_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    function automatic logic [31:0] io_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + 32'h40 + (32'(idx) << 2);
    endfunction

    assign idx_d        = idx_q + 1'b1;
    assign id_bad       = periph_r_id_i != ID_WIDTH'(PERIPH_ID);
    assign unused_rdata = ^periph_r_data_i[30:8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            req_q    <= 1'b0;
            wen_q    <= 1'b0;
            add_q    <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            job_id_q <= '0;
            for (int i = 0; i < N_REGS; i++) shadow_q[i] <= '0;
`ifdef CFG_MASTER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            if (cfg_we_i && !busy_q && 32'(cfg_idx_i) < N_REGS)
                shadow_q[cfg_idx_i] <= cfg_data_i;
            done_q <= 1'b0;

            // responses are only looked at in *_RSP states, so an r_valid in the grant cycle is dropped
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i && !busy_q) begin
                        state_q <= S_ACQ_REQ;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        idx_q   <= '0;
                        req_q   <= 1'b1;
                        wen_q   <= 1'b1;
                        add_q   <= ADDR_ACQUIRE;
                        data_q  <= '0;
                    end
                end
                S_ACQ_REQ: begin
                    if (periph_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_ACQ_RSP;
                    end
                end
                S_ACQ_RSP: begin
                    if (periph_r_valid_i) begin
                        if (id_bad) error_q <= 1'b1;
                        if (periph_r_data_i[31]) begin
                            state_q <= S_BACKOFF;
                            retry_q <= RETRY_W'(RETRY_CYCLES - 1);
                        end else begin
                            job_id_q <= periph_r_data_i[7:0];
                            state_q  <= S_WR_REQ;
                            req_q    <= 1'b1;
                            wen_q    <= 1'b0;
                            add_q    <= io_addr('0);
                            data_q   <= shadow_q[0];
                        end
                    end
                end
                S_BACKOFF: begin
                    if (retry_q == '0) begin
                        state_q <= S_ACQ_REQ;
                        req_q   <= 1'b1;
                        wen_q   <= 1'b1;
                        add_q   <= ADDR_ACQUIRE;
                    end else begin
                        retry_q <= retry_q - 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (periph_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_WR_RSP;
                    end
                end
                S_WR_RSP: begin
                    if (periph_r_valid_i) begin
                        if (id_bad) error_q <= 1'b1;
                        req_q <= 1'b1;
                        wen_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_TRIG_REQ;
                            add_q   <= ADDR_TRIGGER;
                            data_q  <= '0;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= S_WR_REQ;
                            add_q   <= io_addr(idx_d);
                            data_q  <= shadow_q[idx_d];
                        end
                    end
                end
                S_TRIG_REQ: begin
                    if (periph_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= S_TRIG_RSP;
                    end
                end
                S_TRIG_RSP: begin
                    if (periph_r_valid_i) begin
                        if (id_bad) error_q <= 1'b1;
                        state_q <= S_WAIT_EVT;
`ifdef CFG_MASTER_TIMEOUT_EN
                        tmo_q   <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                S_WAIT_EVT: begin
                    if (evt_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
`ifdef CFG_MASTER_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign job_id_o      = job_id_q;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_be_o   = 4'hF;
    assign periph_data_o = data_q;
    assign periph_id_o   = ID_WIDTH'(PERIPH_ID);

endmodule

// File: tb/tb_multi_dataflow_cfg_master.sv
// tb_multi_dataflow_cfg_master: randomized periph slave plus job-level reference model for multi_dataflow_cfg_master.
// The timeout scenario runs only when CFG_MASTER_TIMEOUT_EN is defined.
module tb_multi_dataflow_cfg_master;

    localparam int          N     = 26;
    localparam int          IW    = $clog2(N);
    localparam int          IDW   = 10;
    localparam logic [31:0] BASE  = 32'h1A10_0000;
    localparam int          RETRY = 16;
    localparam int          TMO   = 100;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            cfg_we_i = 1'b0;
    logic [IW-1:0]   cfg_idx_i = '0;
    logic [31:0]     cfg_data_i = '0;
    logic            start_i = 1'b0;
    logic            evt_i = 1'b0;
    logic            busy_o, done_o, error_o;
    logic [7:0]      job_id_o;
    logic            periph_req_o;
    logic            periph_gnt_i = 1'b0;
    logic [31:0]     periph_add_o;
    logic            periph_wen_o;
    logic [3:0]      periph_be_o;
    logic [31:0]     periph_data_o;
    logic [IDW-1:0]  periph_id_o;
    logic [31:0]     periph_r_data_i = '0;
    logic            periph_r_valid_i = 1'b0;
    logic [IDW-1:0]  periph_r_id_i = '0;

    multi_dataflow_cfg_master #(
        .N_REGS(N), .BASE_ADDR(BASE), .ID_WIDTH(IDW), .PERIPH_ID(0),
        .RETRY_CYCLES(RETRY), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
        .cfg_data_i(cfg_data_i), .start_i(start_i), .evt_i(evt_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .job_id_o(job_id_o),
        .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
        .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
        .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o), .periph_r_data_i(periph_r_data_i),
        .periph_r_valid_i(periph_r_valid_i), .periph_r_id_i(periph_r_id_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] shadow_m [N];
    txn_t        obs_q [$];
    int          acq_gnt_cyc [$];

    // slave / job knobs
    int          g_refuse, g_gmin, g_gmax, g_rmax, g_bad_idx, g_early_idx, g_edly;
    bit          g_spur, g_same_cfg;
    logic [7:0]  g_jid;

    // slave state
    bit          pend, pend_trig, in_req;
    int          pend_wait, stall, gdly, evt_cnt;
    logic [31:0] pend_data;
    logic [IDW-1:0] pend_id;
    txn_t        lat;
    int          acq_seen, wr_seen, trig_rsp_cyc, evt_cyc, stall_bad, done_cnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_o) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // behavioural periph slave: random grant stall and response delay, scripted ACQUIRE answers
    initial begin
        pend = 0; in_req = 0; evt_cnt = -1;
        forever begin
            @(negedge clk);
            periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = '0; periph_r_id_i = '0; evt_i = 0;
            if (rst_i) begin
                pend = 0; in_req = 0; evt_cnt = -1;
            end else begin
                if (evt_cnt == 0) begin
                    evt_i = 1; evt_cyc = cyc; evt_cnt = -1;
                end else if (evt_cnt > 0) evt_cnt--;
                if (pend) begin
                    if (pend_wait == 0) begin
                        periph_r_valid_i = 1; periph_r_data_i = pend_data; periph_r_id_i = pend_id;
                        pend = 0;
                        if (pend_trig) begin
                            trig_rsp_cyc = cyc;
                            if (g_edly >= 0) evt_cnt = g_edly;
                        end
                    end else pend_wait--;
                end
                if (periph_req_o) begin
                    if (!in_req) begin
                        in_req = 1; stall = 0; gdly = $urandom_range(g_gmax, g_gmin);
                        lat.addr = periph_add_o; lat.wen = periph_wen_o; lat.data = periph_data_o;
                    end else if (periph_add_o !== lat.addr || periph_wen_o !== lat.wen ||
                                 periph_data_o !== lat.data) stall_bad++;
                    if (stall >= gdly) begin
                        periph_gnt_i = 1; in_req = 0;
                        obs_q.push_back(lat);
                        pend = 1; pend_wait = $urandom_range(g_rmax, 0);
                        pend_id = '0; pend_data = $urandom; pend_trig = 0;
                        if (lat.wen && lat.addr == BASE + 32'h4) begin
                            acq_gnt_cyc.push_back(cyc);
                            if (acq_seen < g_refuse) pend_data = 32'h8000_0000 | $urandom;
                            else pend_data = {1'b0, pend_data[30:8], g_jid};
                            acq_seen++;
                        end else if (!lat.wen && lat.addr == BASE) begin
                            pend_trig = 1;
                        end else begin
                            if (wr_seen == g_bad_idx) pend_id = IDW'(5);
                            if (wr_seen == g_early_idx) evt_i = 1;
                            wr_seen++;
                        end
                        if (g_spur && !periph_r_valid_i) begin
                            periph_r_valid_i = 1; periph_r_data_i = 32'hFFFF_FFFF; periph_r_id_i = IDW'(7);
                        end
                    end else stall++;
                end
            end
        end
    end

    task automatic set_defaults();
        g_refuse = 0; g_gmin = 0; g_gmax = 0; g_rmax = 0; g_bad_idx = -1;
        g_early_idx = -1; g_edly = 10; g_spur = 0; g_same_cfg = 0; g_jid = 8'h03;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] d);
        @(negedge clk);
        cfg_we_i = 1; cfg_idx_i = IW'(idx); cfg_data_i = d;
        shadow_m[idx] = d;
        @(negedge clk);
        cfg_we_i = 0;
    endtask

    task automatic prep_job();
        obs_q.delete(); acq_gnt_cyc.delete();
        acq_seen = 0; wr_seen = 0; trig_rsp_cyc = -1; evt_cyc = -1;
        stall_bad = 0; done_cnt = 0; pend = 0; in_req = 0; evt_cnt = -1;
    endtask

    // one job: start, let the slave serve it, then compare against the job-level model
    task automatic run_job();
        int s, dc, exp_n, wi, sidx, exp_done;
        logic [31:0] exp_a, exp_d, sdat;
        logic exp_w;
        bit got;
        @(negedge clk);
        prep_job();
        start_i = 1; s = cyc;
        if (g_same_cfg) begin
            sidx = $urandom_range(N - 1, 0); sdat = $urandom;
            cfg_we_i = 1; cfg_idx_i = IW'(sidx); cfg_data_i = sdat;
            shadow_m[sidx] = sdat;
        end
        @(negedge clk);
        start_i = 0;
        chk("req_after_start", periph_req_o, 1);
        chk("busy_after_start", busy_o, 1);
        chk("err_clr_on_start", error_o, 0);
        cfg_we_i = 1; cfg_idx_i = IW'($urandom_range(N - 1, 0)); cfg_data_i = $urandom;
        @(negedge clk);
        cfg_we_i = 0;
        got = 0;
        for (int k = 0; k < 6000 && !got; k++) begin
            if (done_o) got = 1; else @(negedge clk);
        end
        dc = cyc;
        chk("done_reached", got, 1);
        chk("busy_at_done", busy_o, 1);
        exp_done = (g_edly < 0) ? trig_rsp_cyc + 1 + TMO : evt_cyc + 1;
        chk("done_latency", dc, exp_done);
        chk("job_id", job_id_o, g_jid);
        chk("error", error_o, (g_bad_idx >= 0 || g_edly < 0) ? 1 : 0);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, 0);
        @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("req_stable", stall_bad, 0);
        chk("acq_reads", acq_seen, g_refuse + 1);
        exp_n = g_refuse + N + 2;
        chk("n_txn", obs_q.size(), exp_n);
        for (int i = 0; i < obs_q.size() && i < exp_n; i++) begin
            exp_d = 32'h0;
            if (i <= g_refuse) begin
                exp_a = BASE + 32'h4; exp_w = 1;
            end else if (i <= g_refuse + N) begin
                wi = i - g_refuse - 1;
                exp_a = BASE + 32'h40 + 32'(4 * wi); exp_w = 0; exp_d = shadow_m[wi];
            end else begin
                exp_a = BASE; exp_w = 0;
            end
            chk("txn_addr", obs_q[i].addr, exp_a);
            chk("txn_wen", obs_q[i].wen, exp_w);
            if (!exp_w) chk("txn_data", obs_q[i].data, exp_d);
        end
        if (g_gmax == 0 && g_rmax == 0 && g_refuse == 0)
            chk("launch_latency", trig_rsp_cyc - s, 2 * (N + 2));
        if (g_gmax == 0 && g_rmax == 0)
            for (int i = 0; i + 1 < acq_gnt_cyc.size(); i++)
                chk("backoff_gap", acq_gnt_cyc[i + 1] - acq_gnt_cyc[i], RETRY + 2);
    endtask

    initial begin
        set_defaults();
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
        repeat (3) @(negedge clk);
        rst_i = 0;
        @(negedge clk);
        chk("rst_req", periph_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_job_id", job_id_o, 0);
        chk("rst_be", periph_be_o, 4'hF);
        chk("rst_id", periph_id_o, 0);
        chk("rst_add", periph_add_o, 0);

        // directed: counting pattern, zero-wait slave, ACQUIRE = 3
        for (int i = 0; i < N; i++) cfg_write(i, 32'h100 + i);
        set_defaults();
        run_job();

        // two refusals, then grant
        set_defaults(); g_refuse = 2; g_jid = 8'h5A;
        run_job();

        // 3-cycle grant stall on every transaction, early evt during writes
        set_defaults(); g_gmin = 3; g_gmax = 3; g_early_idx = 4; g_jid = 8'h11;
        run_job();

        // id mismatch on one write response; next job must clear error_o
        set_defaults(); g_bad_idx = 7; g_jid = 8'hC4;
        run_job();

        // random jobs
        for (int j = 0; j < 6; j++) begin
            repeat ($urandom_range(4, 0)) cfg_write($urandom_range(N - 1, 0), $urandom);
            set_defaults();
            g_refuse = $urandom_range(2, 0);
            g_gmax = $urandom_range(3, 0);
            g_gmin = $urandom_range(g_gmax, 0);
            g_rmax = $urandom_range(2, 0);
            g_spur = 1'($urandom_range(1, 0));
            g_same_cfg = 1'($urandom_range(1, 0));
            g_early_idx = ($urandom_range(1, 0) == 1) ? $urandom_range(N - 1, 0) : -1;
            g_edly = $urandom_range(15, 1);
            g_bad_idx = ($urandom_range(3, 0) == 0) ? $urandom_range(N - 1, 0) : -1;
            g_jid = 8'($urandom);
            run_job();
        end

        // reset during write 10: outputs drop next edge, shadow cleared for the next job
        set_defaults();
        @(negedge clk);
        prep_job();
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        for (int k = 0; k < 2000 && wr_seen < 11; k++) @(negedge clk);
        chk("rst_point_reached", (wr_seen >= 11) ? 1 : 0, 1);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        chk("midrst_req", periph_req_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_job_id", job_id_o, 0);
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
        repeat (3) @(negedge clk);
        set_defaults(); g_jid = 8'h77;
        run_job();

`ifdef CFG_MASTER_TIMEOUT_EN
        set_defaults(); g_edly = -1; g_jid = 8'h21;
        run_job();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
